// File: rtl/ili9341_bus_rx_if.sv
// 8080-style panel bus plus the decoded command/pixel results of the receiver.
// master = the bus driver / result consumer, slave = the panel-side receiver.
interface ili9341_bus_rx_if;
    logic        lcd_cs_n;
    logic        lcd_rs;
    logic        lcd_wr;
    logic [7:0]  lcd_data;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_data;
    logic        frame_done;
    logic        lcd_fmark;

    modport master (
        output lcd_cs_n, lcd_rs, lcd_wr, lcd_data,
        input  cmd_valid, cmd, pix_valid, pix_x, pix_y, pix_data, frame_done, lcd_fmark
    );

    modport slave (
        input  lcd_cs_n, lcd_rs, lcd_wr, lcd_data,
        output cmd_valid, cmd, pix_valid, pix_x, pix_y, pix_data, frame_done, lcd_fmark
    );
endinterface

// File: rtl/ili9341_bus_rx.sv
// ILI9341-style bus receiver: decodes commands, tracks the CASET/PASET window, assembles RGB565 pixels.
// Results are registered one cycle after the WR rising edge; the bus has no backpressure.
module ili9341_bus_rx #(
    parameter int         FRAME_CYCLES = 400000,
    parameter int         FMARK_LEN    = 16,
    parameter logic [8:0] DEF_EC       = 9'd319,
    parameter logic [8:0] DEF_EP       = 9'd239
) (
    input  logic              i_clk,
    input  logic              i_reset,
    ili9341_bus_rx_if.slave   bus
);
    localparam int CW = $clog2(FRAME_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR} state_t;

    state_t      state_q, state_d;
    logic        wr_q, rs_q, cs_q;
    logic [7:0]  data_q;
    logic [8:0]  sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [8:0]  x_q, x_d, y_q, y_d;
    logic [8:0]  pstart_q, pstart_d;
    logic        pend_hi_q, pend_hi_d;
    logic [1:0]  pidx_q, pidx_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        pix_valid_q, pix_valid_d;
    logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        frame_done_q, frame_done_d;
    logic [CW-1:0] fm_cnt_q, fm_cnt_d;
    logic        fmark_q, fmark_d;

    logic ev, cmd_ev, dat_ev;

    // Byte is taken when the registered strobe was low and the live strobe is high.
    assign ev     = ~wr_q & bus.lcd_wr & ~cs_q;
    assign cmd_ev = ev & ~rs_q;
    assign dat_ev = ev & rs_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cmd_ev) begin
            case (data_q)
                8'h2A:        state_d = S_CASET;
                8'h2B:        state_d = S_PASET;
                8'h2C, 8'h3C: state_d = S_RAMWR;
                default:      state_d = S_IDLE;
            endcase
        end else if (dat_ev && pidx_q == 2'd3 && (state_q == S_CASET || state_q == S_PASET)) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        sc_d = sc_q; ec_d = ec_q; sp_d = sp_q; ep_d = ep_q;
        x_d = x_q; y_d = y_q;
        pstart_d = pstart_q; pend_hi_d = pend_hi_q;
        pidx_d = pidx_q; phase_d = phase_q; hi_d = hi_q;
        cmd_valid_d = 1'b0; cmd_d = cmd_q;
        pix_valid_d = 1'b0; pix_x_d = pix_x_q; pix_y_d = pix_y_q; pix_data_d = pix_data_q;
        frame_done_d = 1'b0;
        fm_cnt_d = (fm_cnt_q == CW'(FRAME_CYCLES - 1)) ? '0 : fm_cnt_q + 1'b1;
        fmark_d  = (fm_cnt_q < CW'(FMARK_LEN));

        if (cmd_ev) begin
            cmd_valid_d = 1'b1;
            cmd_d       = data_q;
            pidx_d      = 2'd0;
            phase_d     = 1'b0;
            if (data_q == 8'h2C) begin
                x_d = sc_q;
                y_d = sp_q;
            end else if (data_q == 8'h01) begin
                sc_d = '0; ec_d = DEF_EC; sp_d = '0; ep_d = DEF_EP;
                x_d  = '0; y_d  = '0;
            end
        end else if (dat_ev) begin
            case (state_q)
                S_CASET, S_PASET: begin
                    pidx_d = pidx_q + 2'd1;
                    // Only bit 0 of each high byte survives the 9-bit truncation.
                    case (pidx_q)
                        2'd0: pstart_d[8]   = data_q[0];
                        2'd1: pstart_d[7:0] = data_q;
                        2'd2: pend_hi_d     = data_q[0];
                        default: begin
                            if (state_q == S_CASET) begin
                                sc_d = pstart_q;
                                ec_d = {pend_hi_q, data_q};
                            end else begin
                                sp_d = pstart_q;
                                ep_d = {pend_hi_q, data_q};
                            end
                        end
                    endcase
                end
                S_RAMWR: begin
                    if (!phase_q) begin
                        hi_d    = data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d      = 1'b0;
                        pix_valid_d  = 1'b1;
                        pix_x_d      = x_q;
                        pix_y_d      = y_q;
                        pix_data_d   = {hi_q, data_q};
                        frame_done_d = (x_q >= ec_q) && (y_q >= ep_q);
                        if (x_q >= ec_q) begin
                            x_d = sc_q;
                            y_d = (y_q >= ep_q) ? sp_q : y_q + 9'd1;
                        end else begin
                            x_d = x_q + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_q <= 1'b1; rs_q <= 1'b0; cs_q <= 1'b1; data_q <= '0;
            sc_q <= '0; ec_q <= DEF_EC; sp_q <= '0; ep_q <= DEF_EP;
            x_q <= '0; y_q <= '0;
            pstart_q <= '0; pend_hi_q <= 1'b0;
            pidx_q <= '0; phase_q <= 1'b0; hi_q <= '0;
            cmd_valid_q <= 1'b0; cmd_q <= '0;
            pix_valid_q <= 1'b0; pix_x_q <= '0; pix_y_q <= '0; pix_data_q <= '0;
            frame_done_q <= 1'b0;
            fm_cnt_q <= '0; fmark_q <= 1'b0;
        end else begin
            wr_q <= bus.lcd_wr; rs_q <= bus.lcd_rs; cs_q <= bus.lcd_cs_n; data_q <= bus.lcd_data;
            sc_q <= sc_d; ec_q <= ec_d; sp_q <= sp_d; ep_q <= ep_d;
            x_q <= x_d; y_q <= y_d;
            pstart_q <= pstart_d; pend_hi_q <= pend_hi_d;
            pidx_q <= pidx_d; phase_q <= phase_d; hi_q <= hi_d;
            cmd_valid_q <= cmd_valid_d; cmd_q <= cmd_d;
            pix_valid_q <= pix_valid_d; pix_x_q <= pix_x_d; pix_y_q <= pix_y_d; pix_data_q <= pix_data_d;
            frame_done_q <= frame_done_d;
            fm_cnt_q <= fm_cnt_d; fmark_q <= fmark_d;
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd        = cmd_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.pix_data   = pix_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.lcd_fmark  = fmark_q;
endmodule

// File: tb/tb_ili9341_bus_rx.sv
// Bench for ili9341_bus_rx: directed test-plan sequences plus random bus traffic
// compared byte by byte against a queue-based model of the panel protocol.
module tb_ili9341_bus_rx;
    localparam int FC = 100;
    localparam int FL = 4;
    localparam int DEF_EC = 319;
    localparam int DEF_EP = 239;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ili9341_bus_rx_if bus ();

    ili9341_bus_rx #(
        .FRAME_CYCLES(FC),
        .FMARK_LEN   (FL),
        .DEF_EC      (9'd319),
        .DEF_EP      (9'd239)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the panel: mode 0 idle, 1 column, 2 page, 3 memory write.
    int m_mode, m_sc, m_ec, m_sp, m_ep, m_x, m_y;
    int m_params[$];
    int m_have_hi, m_hi;
    int m_last_cmd, m_px, m_py, m_pd;
    int e_cmd_v, e_pix_v, e_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_sc = 0; m_ec = DEF_EC; m_sp = 0; m_ep = DEF_EP; m_x = 0; m_y = 0;
        m_params.delete(); m_have_hi = 0; m_hi = 0;
        m_last_cmd = 0; m_px = 0; m_py = 0; m_pd = 0;
        e_cmd_v = 0; e_pix_v = 0; e_fd = 0;
    endtask

    task automatic model_byte(input bit rs, input int d);
        e_cmd_v = 0; e_pix_v = 0; e_fd = 0;
        if (!rs) begin
            e_cmd_v = 1; m_last_cmd = d; m_params.delete(); m_have_hi = 0;
            case (d)
                'h2A: m_mode = 1;
                'h2B: m_mode = 2;
                'h2C: begin m_x = m_sc; m_y = m_sp; m_mode = 3; end
                'h3C: m_mode = 3;
                'h01: begin
                    m_sc = 0; m_ec = DEF_EC; m_sp = 0; m_ep = DEF_EP;
                    m_x = 0; m_y = 0; m_mode = 0;
                end
                default: m_mode = 0;
            endcase
        end else if (m_mode == 1 || m_mode == 2) begin
            m_params.push_back(d);
            if (m_params.size() == 4) begin
                int s, e;
                s = (m_params[0] * 256 + m_params[1]) % 512;
                e = (m_params[2] * 256 + m_params[3]) % 512;
                if (m_mode == 1) begin m_sc = s; m_ec = e; end
                else             begin m_sp = s; m_ep = e; end
                m_params.delete();
                m_mode = 0;
            end
        end else if (m_mode == 3) begin
            if (!m_have_hi) begin
                m_hi = d; m_have_hi = 1;
            end else begin
                m_have_hi = 0;
                e_pix_v = 1; m_px = m_x; m_py = m_y; m_pd = m_hi * 256 + d;
                e_fd = (m_x >= m_ec && m_y >= m_ep) ? 1 : 0;
                if (m_x >= m_ec) begin
                    m_x = m_sc;
                    m_y = (m_y >= m_ep) ? m_sp : (m_y + 1) % 512;
                end else begin
                    m_x = (m_x + 1) % 512;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("cmd_valid", bus.cmd_valid, e_cmd_v);
        chk("cmd", bus.cmd, m_last_cmd);
        chk("pix_valid", bus.pix_valid, e_pix_v);
        chk("pix_x", bus.pix_x, m_px);
        chk("pix_y", bus.pix_y, m_py);
        chk("pix_data", bus.pix_data, m_pd);
        chk("frame_done", bus.frame_done, e_fd);
    endtask

    // One full WR low/high cycle, check the cycle after the rising edge, then check pulses drop.
    task automatic send(input bit rs, input logic [7:0] d, input bit cs_n);
        @(negedge clk);
        bus.lcd_cs_n = cs_n; bus.lcd_rs = rs; bus.lcd_data = d; bus.lcd_wr = 1'b0;
        @(negedge clk);
        bus.lcd_wr = 1'b1;
        @(negedge clk);
        if (!cs_n) model_byte(rs, int'(d));
        else begin e_cmd_v = 0; e_pix_v = 0; e_fd = 0; end
        check_outputs();
        @(negedge clk);
        chk("cmd_valid_1cyc", bus.cmd_valid, 0);
        chk("pix_valid_1cyc", bus.pix_valid, 0);
        chk("frame_done_1cyc", bus.frame_done, 0);
    endtask

    task automatic cmd(input logic [7:0] d);
        send(1'b0, d, 1'b0);
    endtask

    task automatic dat(input logic [7:0] d);
        send(1'b1, d, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.lcd_wr = 1'b1; bus.lcd_cs_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_cmd", bus.cmd, 0);
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_pix_x", bus.pix_x, 0);
        chk("rst_pix_y", bus.pix_y, 0);
        chk("rst_pix_data", bus.pix_data, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_fmark", bus.lcd_fmark, 0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int tp_x[9];
        int tp_y[9];
        tp_x = '{10, 11, 12, 13, 10, 11, 12, 13, 10};
        tp_y = '{2, 2, 2, 2, 3, 3, 3, 3, 2};
        bus.lcd_cs_n = 1'b1; bus.lcd_rs = 1'b0; bus.lcd_wr = 1'b1; bus.lcd_data = 8'h00;
        model_reset();
        do_reset();

        // FMARK period and width right after reset release
        for (int k = 0; k < 2 * FC + 10; k++) begin
            @(negedge clk);
            chk("fmark", bus.lcd_fmark, ((k % FC) < FL) ? 1 : 0);
        end

        // Window 10..13 x 2..3, nine pixels, wrap back to the window start
        cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0D);
        cmd(8'h2B); dat(8'h00); dat(8'h02); dat(8'h00); dat(8'h03);
        cmd(8'h2C);
        for (int i = 0; i < 9; i++) begin
            logic [15:0] v;
            v = 16'h1000 + 16'(i);
            dat(v[15:8]); dat(v[7:0]);
            chk("tp_x", bus.pix_x, tp_x[i]);
            chk("tp_y", bus.pix_y, tp_y[i]);
            chk("tp_data", bus.pix_data, 32'h1000 + i);
        end

        // Dangling byte dropped by a command, later data ignored
        cmd(8'h2C); dat(8'hF8); dat(8'h00); dat(8'h07);
        chk("tp2_pix", bus.pix_data, 32'hF800);
        cmd(8'h00); dat(8'h12); dat(8'h34);
        chk("tp2_cmd", bus.cmd, 32'h00);

        // Truncated CASET leaves columns alone, PASET narrows to one page
        cmd(8'h01);
        cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00);
        cmd(8'h2B); dat(8'h00); dat(8'h01); dat(8'h00); dat(8'h01);
        cmd(8'h2C);
        for (int i = 0; i < 3; i++) begin dat(8'hAA); dat(8'(i)); end
        chk("tp3_x2", bus.pix_x, 2);
        chk("tp3_y", bus.pix_y, 1);
        cmd(8'h3C); dat(8'h55); dat(8'h66);
        chk("tp4_ramwrc_x", bus.pix_x, 3);
        cmd(8'h2C); dat(8'h55); dat(8'h77);
        chk("tp4_ramwr_x", bus.pix_x, 0);

        // Chip select high: strobes ignored, pixel stream continues
        send(1'b0, 8'h2C, 1'b1);
        send(1'b1, 8'h99, 1'b1);
        dat(8'h01); dat(8'h02);
        chk("tp5_x", bus.pix_x, 1);

        // Random traffic
        for (int it = 0; it < 150; it++) begin
            int op;
            op = $urandom_range(0, 11);
            case (op)
                0, 1: begin
                    int n;
                    cmd(op == 0 ? 8'h2A : 8'h2B);
                    n = $urandom_range(2, 5);
                    if (n > 4) n = 4;
                    for (int j = 0; j < n; j++) begin
                        if (j == 0 || j == 2) dat(8'($urandom_range(0, 3)));
                        else                  dat(8'($urandom_range(0, 255)));
                    end
                end
                2, 3: cmd(8'h2C);
                4:    cmd(8'h3C);
                5:    cmd(8'h01);
                6:    cmd(8'($urandom_range(0, 255)));
                7, 8, 9: repeat ($urandom_range(1, 8)) dat(8'($urandom_range(0, 255)));
                default: send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
            endcase
        end

        // Reset in the middle of a pixel, then check defaults are back
        cmd(8'h2C); dat(8'hDE); dat(8'hAD); dat(8'hBE);
        do_reset();
        dat(8'h11); dat(8'h22);
        cmd(8'h2C); dat(8'h33); dat(8'h44);
        chk("post_rst_x", bus.pix_x, 0);
        chk("post_rst_y", bus.pix_y, 0);
        cmd(8'h2A); dat(8'h01); dat(8'h3F); dat(8'h01); dat(8'h3F);
        cmd(8'h2B); dat(8'h00); dat(8'hEF); dat(8'h00); dat(8'hEF);
        cmd(8'h2C); dat(8'h01); dat(8'h02);
        chk("corner_x", bus.pix_x, 319);
        chk("corner_y", bus.pix_y, 239);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
